// File: rtl/star_scanner_if.sv
// Frame-buffer read port of the star scanner.
// The scanner drives address/enable; the synchronous RAM returns data a cycle later.
interface star_scanner_if #(
   parameter int COLSZ = 3
);
   logic [14:0]      rd_addr;
   logic             rd_en;
   logic [COLSZ-1:0] rd_data;

   modport master (
      output rd_addr,
      output rd_en,
      input  rd_data
   );

   modport slave (
      input  rd_addr,
      input  rd_en,
      output rd_data
   );
endinterface

// File: rtl/star_scanner.sv
// Raster scanner that walks the frame buffer looking for star pixels.
// A pixel is a star if it is neither background nor box-outline colour.
module star_scanner #(
   parameter int XSZ   = 8,
   parameter int YSZ   = 7,
   parameter int COLSZ = 3,
   parameter int XMAX  = 160,
   parameter int YMAX  = 120,
   parameter logic [COLSZ-1:0] BG_COL  = 3'b000,
   parameter logic [COLSZ-1:0] BOX_COL = 3'b010
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            resume,
   star_scanner_if.master  fb,
   output logic [XSZ-1:0]  x_out,
   output logic [YSZ-1:0]  y_out,
   output logic            star_found,
   output logic            frame_done,
   output logic            busy
);

   typedef enum logic [1:0] {IDLE, SCAN, FOUND, DONE} state_t;

   localparam logic [XSZ-1:0] XLAST = XSZ'(XMAX - 1);
   localparam logic [YSZ-1:0] YLAST = YSZ'(YMAX - 1);

   state_t         state;
   logic [XSZ-1:0] ix, issueX, cmpX;
   logic [YSZ-1:0] iy, issueY, cmpY;
   logic           more;
   logic           cmpValid;
   logic           hit;
   logic           ixLast;
   logic           atEnd;
   logic           goStart;
   logic           goResume;
   logic           outLast;

   // y*160+x as shifts and adds
   function automatic logic [14:0] addrOf(
      input logic [XSZ-1:0] x,
      input logic [YSZ-1:0] y
   );
      logic [14:0] yy;
      yy = 15'(y);
      return (yy << 7) + (yy << 5) + 15'(x);
   endfunction

   // Hit decode, raster-end detection and command qualification
   always_comb begin
      hit      = cmpValid && (fb.rd_data != BG_COL)
                          && (fb.rd_data != BOX_COL);
      ixLast   = (ix == XLAST);
      atEnd    = ixLast && (iy == YLAST);
      goStart  = start && (state != SCAN);
      goResume = resume && !start && (state == FOUND);
      outLast  = (x_out == XLAST) && (y_out == YLAST);
   end

   // Scan FSM: issue pipeline, compare stage and registered status outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         fb.rd_addr <= '0;
         fb.rd_en   <= 1'b0;
         x_out      <= '0;
         y_out      <= '0;
         star_found <= 1'b0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
         ix         <= '0;
         iy         <= '0;
         issueX     <= '0;
         issueY     <= '0;
         cmpX       <= '0;
         cmpY       <= '0;
         more       <= 1'b0;
         cmpValid   <= 1'b0;
      end else if (goStart) begin
         state      <= SCAN;
         busy       <= 1'b1;
         star_found <= 1'b0;
         frame_done <= 1'b0;
         fb.rd_en   <= 1'b0;
         cmpValid   <= 1'b0;
         more       <= 1'b1;
         ix         <= '0;
         iy         <= '0;
      end else if (goResume) begin
         star_found <= 1'b0;
         fb.rd_en   <= 1'b0;
         cmpValid   <= 1'b0;
         if (outLast) begin
            // last pixel of the frame was the hit: nothing left to read
            state      <= DONE;
            frame_done <= 1'b1;
         end else begin
            state <= SCAN;
            busy  <= 1'b1;
            more  <= 1'b1;
            ix    <= (x_out == XLAST) ? '0 : x_out + 1'b1;
            iy    <= (x_out == XLAST) ? y_out + 1'b1 : y_out;
         end
      end else if (state == SCAN) begin
         cmpValid <= fb.rd_en;
         cmpX     <= issueX;
         cmpY     <= issueY;
         if (hit) begin
            // the read issued alongside this compare is dropped
            state      <= FOUND;
            busy       <= 1'b0;
            star_found <= 1'b1;
            x_out      <= cmpX;
            y_out      <= cmpY;
            fb.rd_en   <= 1'b0;
            cmpValid   <= 1'b0;
            more       <= 1'b0;
         end else if (more) begin
            fb.rd_en   <= 1'b1;
            fb.rd_addr <= addrOf(ix, iy);
            issueX     <= ix;
            issueY     <= iy;
            if (atEnd) more <= 1'b0;
            ix <= ixLast ? '0 : ix + 1'b1;
            iy <= ixLast ? iy + 1'b1 : iy;
         end else begin
            fb.rd_en <= 1'b0;
            if (!fb.rd_en && cmpValid) begin
               state      <= DONE;
               busy       <= 1'b0;
               frame_done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_star_scanner.sv
// Directed bench for star_scanner with a frame-buffer RAM model.
// Expected hits/frame-ends are queued on each command and popped on events.
module tb_star_scanner;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       resume;
   logic [7:0] x_out;
   logic [6:0] y_out;
   logic       star_found;
   logic       frame_done;
   logic       busy;

   star_scanner_if #(.COLSZ(3)) fb();

   star_scanner dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .resume     (resume),
      .fb         (fb),
      .x_out      (x_out),
      .y_out      (y_out),
      .star_found (star_found),
      .frame_done (frame_done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [2:0] mem [0:19199];
   always @(posedge clk) if (fb.rd_en) fb.rd_data <= mem[fb.rd_addr];

   typedef struct {
      logic       done;
      logic [7:0] x;
      logic [6:0] y;
   } exp_t;
   exp_t sb[$];

   int compared   = 0;
   int mismatched = 0;
   int firstEn, lastEn, enCount, firstAddr, evCyc;
   int t0;

   task automatic check(input string tag, input int obs, input int expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic clearMem();
      for (int i = 0; i < 19200; i++) mem[i] = 3'b000;
   endtask

   task automatic setPix(input int x, input int y, input logic [2:0] c);
      mem[y * 160 + x] = c;
   endtask

   task automatic pushExp(input logic d, input int x, input int y);
      exp_t e;
      e.done = d;
      e.x    = 8'(x);
      e.y    = 7'(y);
      sb.push_back(e);
   endtask

   task automatic doStart(output int ts);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ts = cyc;
   endtask

   task automatic doResume(output int ts);
      resume = 1'b1;
      @(negedge clk);
      resume = 1'b0;
      ts = cyc;
   endtask

   task automatic waitEvent(input string tag, input int budget);
      int   got;
      exp_t e;
      got = 0;
      enCount = 0;
      firstEn = -1;
      lastEn = -1;
      firstAddr = -1;
      evCyc = -1;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (fb.rd_en) begin
            if (firstEn < 0) begin
               firstEn = cyc;
               firstAddr = int'(fb.rd_addr);
            end
            lastEn = cyc;
            enCount++;
         end
         if (star_found || frame_done) begin
            evCyc = cyc;
            got = 1;
            break;
         end
      end
      check({tag, "_event_seen"}, got, 1);
      if (got == 1 && sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, "_done_kind"}, int'(frame_done), int'(e.done));
         check({tag, "_found_kind"}, int'(star_found), int'(!e.done));
         if (!e.done) begin
            check({tag, "_x"}, int'(x_out), int'(e.x));
            check({tag, "_y"}, int'(y_out), int'(e.y));
         end
      end
   endtask

   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      resume = 1'b0;
      clearMem();
      repeat (2) @(negedge clk);
      check("rst_rd_en", int'(fb.rd_en), 0);
      check("rst_rd_addr", int'(fb.rd_addr), 0);
      check("rst_x_out", int'(x_out), 0);
      check("rst_y_out", int'(y_out), 0);
      check("rst_found", int'(star_found), 0);
      check("rst_done", int'(frame_done), 0);
      check("rst_busy", int'(busy), 0);
      reset = 1'b0;
      @(negedge clk);

      // blank frame
      pushExp(1'b1, 0, 0);
      doStart(t0);
      check("blank_busy", int'(busy), 1);
      waitEvent("blank", 19300);
      check("blank_first_en", firstEn - t0, 1);
      check("blank_first_addr", firstAddr, 0);
      check("blank_last_en", lastEn - t0, 19200);
      check("blank_en_count", enCount, 19200);
      check("blank_done_cyc", evCyc - t0, 19202);

      // single star at (5,2)
      clearMem();
      setPix(5, 2, 3'b100);
      pushExp(1'b0, 5, 2);
      doStart(t0);
      waitEvent("single", 400);
      check("single_found_cyc", evCyc - t0, 328);
      check("single_rd_en", int'(fb.rd_en), 0);
      check("single_busy", int'(busy), 0);
      repeat (3) @(negedge clk);
      check("single_hold_found", int'(star_found), 1);
      check("single_hold_x", int'(x_out), 5);
      check("single_hold_y", int'(y_out), 2);

      // box-colour pixel skipped
      clearMem();
      setPix(5, 2, 3'b010);
      setPix(7, 2, 3'b001);
      pushExp(1'b0, 7, 2);
      doStart(t0);
      waitEvent("box", 400);
      check("box_found_cyc", evCyc - t0, 330);

      // start beats resume in the same cycle
      pushExp(1'b0, 7, 2);
      start  = 1'b1;
      resume = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      resume = 1'b0;
      t0 = cyc;
      waitEvent("prio", 400);
      check("prio_found_cyc", evCyc - t0, 330);

      // two adjacent stars with resume
      clearMem();
      setPix(5, 2, 3'b110);
      setPix(6, 2, 3'b011);
      pushExp(1'b0, 5, 2);
      doStart(t0);
      waitEvent("two_a", 400);
      pushExp(1'b0, 6, 2);
      doResume(t0);
      waitEvent("two_b", 10);
      check("two_b_latency_ok", int'((evCyc - t0) <= 4), 1);
      pushExp(1'b1, 0, 0);
      doResume(t0);
      repeat (50) @(negedge clk);
      // start mid-scan must be ignored, otherwise (5,2) is found again
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitEvent("two_end", 19300);
      check("two_end_x_hold", int'(x_out), 6);

      // star in the very last pixel
      clearMem();
      setPix(159, 119, 3'b111);
      pushExp(1'b0, 159, 119);
      doStart(t0);
      waitEvent("corner", 19300);
      check("corner_found_cyc", evCyc - t0, 19202);
      doResume(t0);
      check("corner_done", int'(frame_done), 1);
      check("corner_rd_en", int'(fb.rd_en), 0);
      check("corner_busy", int'(busy), 0);
      check("corner_x_hold", int'(x_out), 159);

      // reset in the middle of a scan
      clearMem();
      doStart(t0);
      repeat (100) @(negedge clk);
      check("mid_rd_en", int'(fb.rd_en), 1);
      reset = 1'b1;
      @(negedge clk);
      check("abort_rd_en", int'(fb.rd_en), 0);
      check("abort_rd_addr", int'(fb.rd_addr), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_x_out", int'(x_out), 0);
      check("abort_y_out", int'(y_out), 0);
      check("abort_done", int'(frame_done), 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      reset = 1'b0;
      check("rst_prio_busy", int'(busy), 0);
      @(negedge clk);
      check("rst_prio_rd_en", int'(fb.rd_en), 0);
      doStart(t0);
      @(negedge clk);
      check("rescan_rd_en", int'(fb.rd_en), 1);
      check("rescan_addr0", int'(fb.rd_addr), 0);
      @(negedge clk);
      check("rescan_addr1", int'(fb.rd_addr), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
